// File: rtl/key_scan_pkg.sv
// Shared types for the key scan debouncer: FSM states and the event record
// carried through the event FIFO.
package key_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      UPDATE
   } fsm_state_t;

   // Width of a key index for a bank of num_keys keys (at least one bit).
   function automatic int key_index_w(input int num_keys);
      return (num_keys > 1) ? $clog2(num_keys) : 1;
   endfunction

   // The event record is sized for the largest supported bank so one type
   // serves every instance; narrower banks zero-extend the index.
   localparam int MAX_KEYS    = 256;
   localparam int KEY_FIELD_W = key_index_w(MAX_KEYS);

   typedef struct packed {
      logic [KEY_FIELD_W-1:0] key;
      logic                   pressed;
   } key_event_t;

endpackage

// File: rtl/key_scan_debouncer_if.sv
// Event stream from the debouncer to the application: valid/ready handshake
// carrying the key index and press/release flag of the FIFO head.
interface key_scan_debouncer_if #(
   parameter int KEY_W = 3
);
   logic             event_valid;
   logic             event_ready;
   logic [KEY_W-1:0] event_key;
   logic             event_pressed;

   modport master (
      output event_valid,
      output event_key,
      output event_pressed,
      input  event_ready
   );

   modport slave (
      input  event_valid,
      input  event_key,
      input  event_pressed,
      output event_ready
   );
endinterface

// File: rtl/key_event_fifo.sv
// Small first-word-fall-through FIFO of key events. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate count.
module key_event_fifo
   import key_scan_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  key_event_t push_data,
   output logic       full,
   input  logic       pop,
   output key_event_t pop_data,
   output logic       empty
);
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [ADDR_W:0] wr_ptr;
   logic [ADDR_W:0] rd_ptr;
   key_event_t      mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                  (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

   // Head is presented combinationally; an empty FIFO shows an all-zero record.
   assign pop_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

   // Pointer advance; both sides judge full/empty on the pre-edge pointers.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      end
   end

   // Storage write; contents need no reset since empty masks the head.
   always_ff @(posedge clock) begin
      if (push && !full) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
   end

endmodule

// File: rtl/key_scan_debouncer.sv
// Time-multiplexed key debouncer: one filter engine visits every key in turn
// on a scan tick, keeps per-key stable level and disagreement counter, and
// queues press/release events into a small FWFT FIFO.
module key_scan_debouncer
   import key_scan_pkg::*;
#(
   parameter int NUM_KEYS           = 8,
   parameter int CLOCK_HZ           = 12_000_000,
   parameter int SCAN_HZ            = 10_000,
   parameter int FILTER_COUNTER_MAX = 3,
   parameter int EVENT_FIFO_DEPTH   = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] async_in,
   output logic [NUM_KEYS-1:0] key_state,
   output logic                overflow,
   input  logic                overflow_clear,
   key_scan_debouncer_if.master evt
);
   localparam int DIV   = CLOCK_HZ / (SCAN_HZ * NUM_KEYS);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int KEY_W = key_index_w(NUM_KEYS);
   localparam int CNT_W = $clog2(FILTER_COUNTER_MAX + 1);

   if (NUM_KEYS < 2 || NUM_KEYS > MAX_KEYS) begin : g_bad_num_keys
      $error("NUM_KEYS must be in 2..%0d", MAX_KEYS);
   end
   if (DIV < 3) begin : g_bad_div
      $error("scan divider %0d too small, needs at least 3", DIV);
   end
   if (FILTER_COUNTER_MAX < 1) begin : g_bad_filter
      $error("FILTER_COUNTER_MAX must be at least 1");
   end
   if (EVENT_FIFO_DEPTH < 2 || (EVENT_FIFO_DEPTH & (EVENT_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("EVENT_FIFO_DEPTH must be a power of two, at least 2");
   end

   // Disagreement counter step, pinned at the acceptance threshold.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c >= CNT_W'(FILTER_COUNTER_MAX - 1)) return CNT_W'(FILTER_COUNTER_MAX - 1);
      return c + CNT_W'(1);
   endfunction

   logic [NUM_KEYS-1:0] sync_meta;
   logic [NUM_KEYS-1:0] sync;
   logic [DIV_W-1:0]    div_cnt;
   logic                tick;
   fsm_state_t          state_q;
   fsm_state_t          state_d;
   logic [KEY_W-1:0]    idx;
   logic [CNT_W-1:0]    cnt_mem [NUM_KEYS];

   logic                sample_p0;
   logic                level_p0;
   logic [CNT_W-1:0]    cnt_p0;

   logic                accept;
   logic [CNT_W-1:0]    cnt_next;
   logic                push;
   key_event_t          push_evt;
   key_event_t          head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                unused_key_bits;

   // Two-stage synchronizer on every raw key input.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_meta <= '0;
         sync      <= '0;
      end else begin
         sync_meta <= async_in;
         sync      <= sync_meta;
      end
   end

   assign tick = (div_cnt == DIV_W'(DIV - 1));

   // Scan divider: one tick every DIV cycles, i.e. one key slot.
   always_ff @(posedge clock) begin
      if (reset) div_cnt <= '0;
      else       div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
   end

   // Service FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Service sequence: wait for a tick, read the key's context, write it back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick) state_d = READ;
         READ:    state_d = UPDATE;
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Round-robin key pointer, advanced once per completed service.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx <= '0;
      end else if (state_q == UPDATE) begin
         idx <= (idx == KEY_W'(NUM_KEYS - 1)) ? '0 : idx + KEY_W'(1);
      end
   end

   // READ: capture the sample and stored context of the key being served.
   always_ff @(posedge clock) begin
      if (state_q == READ) begin
         sample_p0 <= sync[idx];
         level_p0  <= key_state[idx];
         cnt_p0    <= cnt_mem[idx];
      end
   end

   // Filter decision from the captured context.
   always_comb begin
      accept   = 1'b0;
      cnt_next = '0;
      if (sample_p0 != level_p0) begin
         if (cnt_p0 == CNT_W'(FILTER_COUNTER_MAX - 1)) accept   = 1'b1;
         else                                          cnt_next = sat_inc(cnt_p0);
      end
   end

   // UPDATE: write back the counter and, on acceptance, the stable level.
   always_ff @(posedge clock) begin
      if (reset) begin
         key_state <= '0;
         for (int i = 0; i < NUM_KEYS; i++) cnt_mem[i] <= '0;
      end else if (state_q == UPDATE) begin
         cnt_mem[idx] <= cnt_next;
         if (accept) key_state[idx] <= sample_p0;
      end
   end

   assign push             = (state_q == UPDATE) && accept;
   assign push_evt.key     = KEY_FIELD_W'(idx);
   assign push_evt.pressed = sample_p0;

   // Sticky drop flag; a drop in the same cycle as a clear wins.
   always_ff @(posedge clock) begin
      if (reset)                    overflow <= 1'b0;
      else if (push && fifo_full)   overflow <= 1'b1;
      else if (overflow_clear)      overflow <= 1'b0;
   end

   key_event_fifo #(
      .DEPTH (EVENT_FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_evt),
      .full      (fifo_full),
      .pop       (evt.event_ready && !fifo_empty),
      .pop_data  (head),
      .empty     (fifo_empty)
   );

   assign evt.event_valid   = !fifo_empty;
   assign evt.event_key     = head.key[KEY_W-1:0];
   assign evt.event_pressed = head.pressed;
   assign unused_key_bits   = ^head.key;

endmodule

// File: tb/tb_key_scan_debouncer.sv
// Bench for key_scan_debouncer: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a cycle-indexed model.
module tb_key_scan_debouncer;
   localparam int NK     = 4;
   localparam int CLK_HZ = 1200;
   localparam int SC_HZ  = 100;
   localparam int FCM    = 3;
   localparam int DEPTH  = 4;
   localparam int DIV    = CLK_HZ / (SC_HZ * NK);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [NK-1:0] async_in = '0;
   logic [NK-1:0] key_state;
   logic          overflow;
   logic          overflow_clear = 1'b0;

   key_scan_debouncer_if #(.KEY_W(2)) evt ();

   key_scan_debouncer #(
      .NUM_KEYS           (NK),
      .CLOCK_HZ           (CLK_HZ),
      .SCAN_HZ            (SC_HZ),
      .FILTER_COUNTER_MAX (FCM),
      .EVENT_FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .async_in       (async_in),
      .key_state      (key_state),
      .overflow       (overflow),
      .overflow_clear (overflow_clear),
      .evt            (evt)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model. Cycle c counts clock edges since reset release; scan
   // slot boundaries fall where c % DIV == DIV-1, slot s serves key s % NK,
   // its sample is taken one cycle later and its result lands one cycle after.
   int            m_cyc = 0;
   logic [NK-1:0] m_d1 = '0;
   logic [NK-1:0] m_d2 = '0;
   logic [NK-1:0] m_ks = '0;
   int            m_cnt [NK];
   logic          m_sample = 1'b0;
   int            m_q [$];
   bit            m_ov = 1'b0;
   bit            m_pop, m_full, m_push;
   int            m_k = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_cyc = 0;
         m_d1  = '0;
         m_d2  = '0;
         m_ks  = '0;
         for (int i = 0; i < NK; i++) m_cnt[i] = 0;
         m_q.delete();
         m_ov  = 1'b0;
      end else begin
         m_pop  = (m_q.size() > 0) && evt.event_ready;
         m_full = (m_q.size() >= DEPTH);
         m_push = 1'b0;
         if (m_cyc >= 2 && (m_cyc - 2) % DIV == DIV - 1) begin
            m_k = ((m_cyc - 1) / DIV - 1) % NK;
            if (m_sample == m_ks[m_k]) m_cnt[m_k] = 0;
            else if (m_cnt[m_k] < FCM - 1) m_cnt[m_k]++;
            else begin
               m_ks[m_k]  = m_sample;
               m_cnt[m_k] = 0;
               m_push     = 1'b1;
            end
         end
         if (m_cyc >= 1 && (m_cyc - 1) % DIV == DIV - 1)
            m_sample = m_d2[(m_cyc / DIV - 1) % NK];
         m_d2 = m_d1;
         m_d1 = async_in;
         if (m_pop) void'(m_q.pop_front());
         if (m_push && m_full)    m_ov = 1'b1;
         else if (overflow_clear) m_ov = 1'b0;
         if (m_push && !m_full) m_q.push_back(m_k * 2 + int'(m_sample));
         m_cyc++;
      end
   end

   // Continuous comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (!reset) begin
         chk("model_key_state", int'(key_state), int'(m_ks));
         chk("model_valid", int'(evt.event_valid), int'(m_q.size() > 0));
         if (m_q.size() > 0) begin
            chk("model_event_key", int'(evt.event_key), m_q[0] / 2);
            chk("model_event_pressed", int'(evt.event_pressed), m_q[0] % 2);
         end
         chk("model_overflow", int'(overflow), int'(m_ov));
      end
   end

   task automatic do_reset(input int n);
      reset          = 1'b1;
      overflow_clear = 1'b0;
      evt.event_ready = 1'b1;
      repeat (n) @(negedge clock);
      chk("reset_key_state", int'(key_state), 0);
      chk("reset_valid", int'(evt.event_valid), 0);
      chk("reset_event_key", int'(evt.event_key), 0);
      chk("reset_event_pressed", int'(evt.event_pressed), 0);
      chk("reset_overflow", int'(overflow), 0);
      reset = 1'b0;
   endtask

   task automatic wait_key(input int k, input logic lvl, input int limit, output int n);
      n = 0;
      while (key_state[k] !== lvl && n < limit) begin
         @(negedge clock);
         n++;
      end
   endtask

   typedef struct {
      logic [NK-1:0] in;
      bit            ready;
      int            hold;
      logic [NK-1:0] exp_ks;
      bit            exp_ov;
   } vec_t;

   vec_t vecs [8];

   int n;
   int seen;
   int ev_key [$];
   int ev_pr  [$];
   int ev_cyc [$];
   int exp_seq [4];
   logic [NK-1:0] ov_pat [5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      vecs[0] = '{4'b0000, 1'b1, 100, 4'b0000, 1'b0};
      vecs[1] = '{4'b0100, 1'b1,  48, 4'b0100, 1'b0};
      vecs[2] = '{4'b0000, 1'b1,  48, 4'b0000, 1'b0};
      vecs[3] = '{4'b1111, 1'b1,  48, 4'b1111, 1'b0};
      vecs[4] = '{4'b0000, 1'b1,  48, 4'b0000, 1'b0};
      vecs[5] = '{4'b1001, 1'b0,  48, 4'b1001, 1'b0};
      vecs[6] = '{4'b0110, 1'b0,  48, 4'b0110, 1'b1};
      vecs[7] = '{4'b0110, 1'b1,  20, 4'b0110, 1'b1};

      // Idle after reset.
      async_in = '0;
      do_reset(3);
      seen = 0;
      repeat (100) begin
         @(negedge clock);
         if (evt.event_valid) seen = 1;
      end
      chk("idle_key_state", int'(key_state), 0);
      chk("idle_valid_seen", seen, 0);
      chk("idle_overflow", int'(overflow), 0);

      // Steady press and release of key 2.
      async_in = '0;
      do_reset(2);
      async_in[2] = 1'b1;
      wait_key(2, 1'b1, 60, n);
      chk("press_latency", n, 35);
      chk("press_within_bound", int'(n <= 2 + FCM * DIV * NK + 2), 1);
      chk("press_valid", int'(evt.event_valid), 1);
      chk("press_key", int'(evt.event_key), 2);
      chk("press_pressed", int'(evt.event_pressed), 1);
      async_in[2] = 1'b0;
      wait_key(2, 1'b0, 60, n);
      chk("release_latency", n, 36);
      chk("release_valid", int'(evt.event_valid), 1);
      chk("release_key", int'(evt.event_key), 2);
      chk("release_pressed", int'(evt.event_pressed), 0);

      // One-visit glitch on key 1.
      async_in = '0;
      do_reset(2);
      async_in[1] = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clock);
         if (evt.event_valid || key_state[1]) seen = 1;
      end
      async_in[1] = 1'b0;
      repeat (60) begin
         @(negedge clock);
         if (evt.event_valid || key_state[1]) seen = 1;
      end
      chk("glitch_ignored", seen, 0);

      // Five events into a four-entry FIFO with the consumer stalled.
      async_in = '0;
      do_reset(2);
      evt.event_ready = 1'b0;
      ov_pat[0] = 4'b0001;
      ov_pat[1] = 4'b1001;
      ov_pat[2] = 4'b1000;
      ov_pat[3] = 4'b0000;
      ov_pat[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         async_in = ov_pat[i];
         repeat (48) @(negedge clock);
         chk("ovf_key_state_tracks", int'(key_state), int'(ov_pat[i]));
      end
      chk("ovf_flag_set", int'(overflow), 1);
      exp_seq[0] = 0 * 2 + 1;
      exp_seq[1] = 3 * 2 + 1;
      exp_seq[2] = 0 * 2 + 0;
      exp_seq[3] = 3 * 2 + 0;
      evt.event_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("ovf_drain_valid", int'(evt.event_valid), 1);
         chk("ovf_drain_event", int'(evt.event_key) * 2 + int'(evt.event_pressed), exp_seq[i]);
         @(negedge clock);
      end
      chk("ovf_drained_empty", int'(evt.event_valid), 0);
      chk("ovf_flag_sticky", int'(overflow), 1);
      overflow_clear = 1'b1;
      @(negedge clock);
      overflow_clear = 1'b0;
      chk("ovf_flag_cleared", int'(overflow), 0);

      // All four keys pressed together.
      async_in = '0;
      do_reset(2);
      async_in = 4'b1111;
      ev_key.delete();
      ev_pr.delete();
      ev_cyc.delete();
      for (int c = 0; c < 80; c++) begin
         if (evt.event_valid) begin
            ev_key.push_back(int'(evt.event_key));
            ev_pr.push_back(int'(evt.event_pressed));
            ev_cyc.push_back(c);
         end
         @(negedge clock);
      end
      chk("all_event_count", ev_key.size(), 4);
      for (int i = 0; i < ev_key.size() && i < 4; i++) begin
         chk("all_event_key", ev_key[i], i);
         chk("all_event_pressed", ev_pr[i], 1);
         chk("all_event_cycle", ev_cyc[i], 29 + DIV * i);
      end

      // Reset during READ of key 3's accepting visit.
      async_in = '0;
      do_reset(2);
      async_in[3] = 1'b1;
      repeat (36) @(negedge clock);
      chk("abort_pre_key_state", int'(key_state[3]), 0);
      do_reset(1);
      chk("abort_key_state", int'(key_state[3]), 0);
      chk("abort_no_event", int'(evt.event_valid), 0);
      wait_key(3, 1'b1, 60, n);
      chk("abort_fresh_latency", n, 38);
      chk("abort_event_key", int'(evt.event_key), 3);
      chk("abort_event_pressed", int'(evt.event_pressed), 1);

      // Directed vector table.
      async_in = '0;
      do_reset(2);
      for (int i = 0; i < 8; i++) begin
         async_in        = vecs[i].in;
         evt.event_ready = vecs[i].ready;
         repeat (vecs[i].hold) @(negedge clock);
         chk("vec_key_state", int'(key_state), int'(vecs[i].exp_ks));
         chk("vec_overflow", int'(overflow), int'(vecs[i].exp_ov));
      end
      chk("vec_drained", int'(evt.event_valid), 0);

      // Randomized traffic against the model.
      async_in = '0;
      do_reset(2);
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         for (int k = 0; k < NK; k++)
            if ($urandom_range(0, 29) == 0) async_in[k] = ~async_in[k];
         evt.event_ready = ($urandom_range(0, 2) != 0);
         overflow_clear  = ($urandom_range(0, 49) == 0);
      end
      overflow_clear = 1'b0;
      repeat (4) @(negedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_scan_debouncer.md
# key_scan_debouncer

Time-multiplexed debounce controller for the board's key bank. A single shared filter engine serves all `NUM_KEYS` inputs in round-robin order, replacing one `debounce` instance per key. It keeps a per-key stable state and counter, and publishes press/release events through a small valid/ready event FIFO. It sits between the raw key pins (already inverted to active-high at top level) and the application logic.

## Interface
- `NUM_KEYS`, 8: number of key inputs; must be ≥2.
- `CLOCK_HZ`, 12_000_000: clock frequency.
- `SCAN_HZ`, 10_000: per-key sampling rate.
- `FILTER_COUNTER_MAX`, 3: number of consecutive differing samples needed to accept a new level; must be ≥1.
- `EVENT_FIFO_DEPTH`, 4: event FIFO entries; must be a power of two, ≥2.
- `clock` input, 1: sole clock.
- `reset` input, 1: synchronous, active-high.
- `async_in` input, NUM_KEYS: raw key levels, 1 = pressed, asynchronous.
- `key_state` output, NUM_KEYS: debounced stable level per key.
- `event_valid` output, 1: FIFO head holds an event.
- `event_ready` input, 1: consumer accepts the head event.
- `event_key` output, $clog2(NUM_KEYS): key index of the head event.
- `event_pressed` output, 1: 1 = press, 0 = release.
- `overflow` output, 1: sticky flag, set when an event is dropped.
- `overflow_clear` input, 1: clears `overflow`.

## Operation
- Synchronization: each bit of `async_in` passes through a 2-FF synchronizer. All filtering uses the synchronized value `sync[i]`.
- Scan tick:
  - Divider constant `DIV = CLOCK_HZ/(SCAN_HZ*NUM_KEYS)`, integer division.
  - An elaboration-time check requires `DIV ≥ 3`.
  - The divider counts 0..DIV-1 and emits a one-cycle `tick` at DIV-1, then wraps to 0.
- FSM with three states:
  - IDLE: on `tick`, go to READ.
  - READ: latch `sync[idx]`, `state[idx]` and `cnt[idx]`; go to UPDATE.
  - UPDATE: write back results, advance `idx`, return to IDLE.
- `idx` wraps from NUM_KEYS-1 to 0.
- Per-key update in UPDATE, using the values latched in READ:
  - sample == state: `cnt` ← 0.
  - sample != state and `cnt < FILTER_COUNTER_MAX-1`: `cnt` ← `cnt+1`.
  - sample != state and `cnt == FILTER_COUNTER_MAX-1`: `state` ← sample, `cnt` ← 0, push event {idx, sample}.
- Counter width is `$clog2(FILTER_COUNTER_MAX+1)`; the counter never exceeds FILTER_COUNTER_MAX-1.
- Push when full:
  - The event is dropped, `overflow` ← 1, and `state` still updates.
  - Fullness is judged on the pre-cycle count, so a simultaneous pop does not make room.
- Pop occurs when `event_valid && event_ready`.
- `overflow_clear` clears `overflow`. A set and a clear in the same cycle leave `overflow` at 1.

## Timing
- Reset values:
  - `key_state` = 0, all counters = 0, `idx` = 0, divider = 0, FSM = IDLE.
  - FIFO empty: `event_valid` = 0, `event_key` = 0, `event_pressed` = 0.
  - `overflow` = 0.
- Reset asserted mid-service aborts the service: no write-back, no push.
- `key_state[i]` changes on the clock edge that ends UPDATE.
- The pushed event shows `event_valid` = 1 on the following cycle; the FIFO is first-word-fall-through.
- Worst-case input-to-`key_state` latency: 2 sync cycles + FILTER_COUNTER_MAX × DIV × NUM_KEYS + 2 cycles.
- A glitch shorter than (FILTER_COUNTER_MAX-1) visits never changes `key_state`.
- Events leave in push order. `event_key` and `event_pressed` hold stable while `event_valid` = 1 and `event_ready` = 0.

## Structure
- Shared package `key_scan_pkg` holds:
  - `fsm_state_t` enum {IDLE, READ, UPDATE}.
  - `key_event_t` packed struct {key, pressed}, where the key width is derived from NUM_KEYS by a function in the package.
- Sub-module `key_event_fifo`:
  - Synchronous FWFT FIFO of `key_event_t`.
  - Ports: push/full, pop/empty.
  - Pointers are one bit wider than the address for the full/empty distinction.

## Test plan
Bench configuration: NUM_KEYS=4, CLOCK_HZ=1200, SCAN_HZ=100 (DIV=3), FILTER_COUNTER_MAX=3, EVENT_FIFO_DEPTH=4, `event_ready`=1 unless noted.

- Reset then idle inputs: after 100 cycles, `key_state` = 4'b0000, `event_valid` never rises, `overflow` = 0.
- Hold `async_in[2]`=1 steadily: `key_state[2]` rises on the 3rd visit to key 2, within 2+36+2 cycles. One event appears: key=2, pressed=1. Releasing the key gives key=2, pressed=0.
- 1-visit glitch on `async_in[1]` (high for 12 cycles, then low): `key_state[1]` stays 0 and no event is produced.
- `event_ready`=0, press and release keys 0 and 3 alternately to create 5 events: FIFO holds the first 4 in order, the 5th is dropped, and `overflow`=1 while `key_state` still tracks the inputs. Then pulse `overflow_clear`: `overflow`=0.
- Simultaneous press on all four keys: events emitted in order key 0,1,2,3, one per scan slot, all with pressed=1.
- Assert `reset` for 1 cycle in READ while key 3 is one visit from acceptance: `key_state[3]` = 0 and no event. Acceptance then takes 3 fresh visits after reset.
